gpio_cfg_shift_loader: RTL and testbench
========================================

// Module: gpio_cfg_shift_loader
// PURPOSE
// - Consumer end of the GPIO default-config path: captures the pad's hard-wired default word after reset,
//   then accepts run-time overrides from the housekeeping serial config chain (daisy-chained across pads).
// - One instance per GPIO pad, beside the pad's defaults tie-block; cfg_out drives pad/control muxing.
// PARAMETERS
// - CFG_W   10   config word width; must match the width of the gpio_defaults bus
// PORTS
// - clk              in   1      single system clock; all state on rising edge
// - resetn           in   1      asynchronous, active-low reset
// - gpio_defaults    in   CFG_W  static default word from the pad's defaults tie-block
// - cfg_reload       in   1      1-cycle pulse: reapply gpio_defaults to cfg_out
// - serial_shift     in   1      shift enable for the config chain
// - serial_data_in   in   1      chain data in; MSB first
// - serial_load      in   1      1-cycle pulse: transfer shift register to cfg_out
// - serial_data_out  out  1      chain data out to the next pad; registered shift-register MSB
// - cfg_out          out  CFG_W  active pad configuration word
// - cfg_valid        out  1      high once cfg_out holds defaults or a loaded word
// - short_load       out  1      sticky: a serial_load arrived before SR_W bits were shifted
// BEHAVIOUR
// - Reset (async assert): cfg_out=0, cfg_valid=0, shift_reg=0, serial_data_out=0, bit_cnt=0, short_load=0,
//   state=INIT. Release is taken synchronously on the next clk edge.
// - FSM states INIT -> RUN. INIT: on the first edge with resetn high, cfg_out<=gpio_defaults,
//   cfg_valid<=1, go RUN. INIT ignores serial_shift, serial_load and cfg_reload.
// - RUN, shift: when serial_shift=1, shift_reg<={shift_reg[SR_W-2:0],serial_data_in},
//   serial_data_out<=shift_reg[SR_W-1]. That is one bit of delay per pad; a word needs SR_W shifts.
// - bit_cnt counts shifts since the last load or reload. It saturates at SR_W and never wraps.
// - RUN, serial_load=1 with bit_cnt==SR_W (and checks pass): cfg_out<=data field of shift_reg,
//   visible 1 cycle after the pulse. Also bit_cnt<=0 and short_load<=0.
// - serial_load=1 with bit_cnt<SR_W: cfg_out unchanged, short_load<=1, bit_cnt unchanged.
// - Shift and load in the same cycle: the load uses the pre-shift shift_reg, and the shift still occurs.
//   bit_cnt then becomes 1 if the load is accepted; otherwise it increments, saturating.
// - cfg_reload=1: cfg_out<=gpio_defaults, bit_cnt<=0, short_load<=0. It has priority over serial_load,
//   and the shift still occurs. shift_reg is never cleared except by reset.
// - Reset asserted mid-shift or mid-load: all state returns to reset values immediately, with no
//   partial cfg update. The INIT sequence repeats on release.
// - cfg_valid stays 1 in RUN. gpio_defaults is treated as static and is sampled only in INIT or on cfg_reload.
// CONFIGURATION
// - Macro GPIO_CFG_PARITY_EN. Defined: SR_W=CFG_W+1, with shift_reg[0] as the even-parity bit and the data
//   field at [SR_W-1:1]. A load with bit_cnt==SR_W and odd XOR over all SR_W bits is rejected:
//   cfg_out unchanged, bit_cnt<=0, added port parity_err (out, 1) <= 1.
//   parity_err is sticky and is cleared by an accepted load, by cfg_reload or by reset.
// - Not defined: SR_W=CFG_W, the data field is shift_reg[CFG_W-1:0], and there is no parity_err port.
// STRUCTURE
// - Package gpio_cfg_pkg:
//   - CFG_W;
//   - state enum {INIT,RUN};
//   - field index constants: MGMT_EN=0, OUT_DIS=1, HOLDOVER=2, INP_DIS=3, IB_MODE=4, ANA_EN=5,
//     ANA_SEL=6, ANA_POL=7, SLOW_SLEW=8, DRIVE=9.
// - One sub-module, gpio_cfg_shift_reg: shift_reg, serial_data_out and the saturating bit_cnt.
//   Load/reload/FSM logic stays in this top level.
// TESTING
// - Release reset with gpio_defaults=10'h00A -> cfg_out=0 and cfg_valid=0 during reset;
//   cfg_out=10'h00A and cfg_valid=1 one edge after release.
// - Shift 10'h3C5 MSB-first (10 cycles), then pulse serial_load -> cfg_out=10'h3C5 next cycle,
//   short_load=0. serial_data_out replays the previous shift_reg contents, MSB first.
// - Shift 4 bits, then serial_load -> cfg_out unchanged and short_load=1.
//   A following cfg_reload -> cfg_out=gpio_defaults and short_load=0.
// - Shift and serial_load together after 10 shifts of 10'h155 -> cfg_out=10'h155 and bit_cnt=1.
//   cfg_reload with serial_load in the same cycle -> cfg_out=gpio_defaults.
// - Assert resetn low mid-shift (after 5 bits) -> all outputs return to 0 asynchronously;
//   after release, cfg_out=gpio_defaults.
// - GPIO_CFG_PARITY_EN: shift 11 bits {10'h3C5, parity 0} -> accepted. Flip one bit -> cfg_out unchanged,
//   parity_err=1, and parity_err clears on the next good load.

Source files
------------

// File: rtl/gpio_cfg_pkg.sv
// Shared types and constants for the GPIO pad configuration loader.
// GPIO_CFG_PARITY_EN adds an even-parity bit to the serial word.
package gpio_cfg_pkg;

  localparam int CFG_W = 10;

`ifdef GPIO_CFG_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Bit positions inside the pad configuration word
  localparam int MGMT_EN   = 0;
  localparam int OUT_DIS   = 1;
  localparam int HOLDOVER  = 2;
  localparam int INP_DIS   = 3;
  localparam int IB_MODE   = 4;
  localparam int ANA_EN    = 5;
  localparam int ANA_SEL   = 6;
  localparam int ANA_POL   = 7;
  localparam int SLOW_SLEW = 8;
  localparam int DRIVE     = 9;

endpackage

// File: rtl/gpio_cfg_shift_reg.sv
// Config-chain shift register with registered chain output and a saturating
// count of shifts since the last accepted word.
module gpio_cfg_shift_reg #(
  parameter int SR_W = 10
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            shift_en,
  input  logic            data_in,
  input  logic            cnt_clr,
  output logic [SR_W-1:0] shift_reg,
  output logic            data_out,
  output logic            cnt_full
);

  localparam int CNT_W = $clog2(SR_W + 1);

  logic [SR_W-1:0]  sr_q, sr_d;
  logic             dout_q, dout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sr_d   = sr_q;
    dout_d = dout_q;
    cnt_d  = cnt_q;
    if (shift_en) begin
      sr_d   = {sr_q[SR_W-2:0], data_in};
      dout_d = sr_q[SR_W-1];
    end
    // A clear coinciding with a shift counts that shift as the first of the next word
    if (cnt_clr) begin
      cnt_d = shift_en ? CNT_W'(1) : '0;
    end else if (shift_en && (cnt_q != CNT_W'(SR_W))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sr_q   <= '0;
      dout_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sr_q   <= sr_d;
      dout_q <= dout_d;
      cnt_q  <= cnt_d;
    end
  end

  assign shift_reg = sr_q;
  assign data_out  = dout_q;
  assign cnt_full  = (cnt_q == CNT_W'(SR_W));

endmodule

// File: rtl/gpio_cfg_shift_loader.sv
// Per-pad config loader: applies hard-wired defaults after reset, then takes
// serial overrides. GPIO_CFG_PARITY_EN enables parity checking and parity_err.
//
// state | meaning
// INIT  | first edge after reset release: latch gpio_defaults
// RUN   | normal operation: shift, load, reload
module gpio_cfg_shift_loader #(
  parameter int CFG_W = gpio_cfg_pkg::CFG_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [CFG_W-1:0] gpio_defaults,
  input  logic             cfg_reload,
  input  logic             serial_shift,
  input  logic             serial_data_in,
  input  logic             serial_load,
  output logic             serial_data_out,
  output logic [CFG_W-1:0] cfg_out,
  output logic             cfg_valid,
`ifdef GPIO_CFG_PARITY_EN
  output logic             parity_err,
`endif
  output logic             short_load
);

  import gpio_cfg_pkg::*;

  localparam int SR_W = CFG_W + PAR_W;

  state_e           state_q, state_d;
  logic [CFG_W-1:0] cfg_q, cfg_d;
  logic             valid_q, valid_d;
  logic             short_q, short_d;
  logic             shift_en, cnt_clr, cnt_full;
  logic [SR_W-1:0]  shift_reg;
`ifdef GPIO_CFG_PARITY_EN
  logic             perr_q, perr_d;
`endif

  assign shift_en = serial_shift && (state_q == RUN);

  gpio_cfg_shift_reg #(
    .SR_W (SR_W)
  ) u_shift_reg (
    .clk       (clk),
    .resetn    (resetn),
    .shift_en  (shift_en),
    .data_in   (serial_data_in),
    .cnt_clr   (cnt_clr),
    .shift_reg (shift_reg),
    .data_out  (serial_data_out),
    .cnt_full  (cnt_full)
  );

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    valid_d = valid_q;
    short_d = short_q;
    cnt_clr = 1'b0;
`ifdef GPIO_CFG_PARITY_EN
    perr_d  = perr_q;
`endif
    case (state_q)
      INIT: begin
        cfg_d   = gpio_defaults;
        valid_d = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        if (cfg_reload) begin
          cfg_d   = gpio_defaults;
          short_d = 1'b0;
          cnt_clr = 1'b1;
`ifdef GPIO_CFG_PARITY_EN
          perr_d  = 1'b0;
`endif
        end else if (serial_load) begin
          if (cnt_full) begin
            cnt_clr = 1'b1;
`ifdef GPIO_CFG_PARITY_EN
            // Even parity: a good word XORs to zero across all SR_W bits
            if (^shift_reg) begin
              perr_d = 1'b1;
            end else begin
              cfg_d   = shift_reg[SR_W-1 -: CFG_W];
              short_d = 1'b0;
              perr_d  = 1'b0;
            end
`else
            cfg_d   = shift_reg[SR_W-1 -: CFG_W];
            short_d = 1'b0;
`endif
          end else begin
            short_d = 1'b1;
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= INIT;
      cfg_q   <= '0;
      valid_q <= 1'b0;
      short_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      valid_q <= valid_d;
      short_q <= short_d;
    end
  end

`ifdef GPIO_CFG_PARITY_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign parity_err = perr_q;
`endif

  assign cfg_out    = cfg_q;
  assign cfg_valid  = valid_q;
  assign short_load = short_q;

endmodule

// File: tb/tb_gpio_cfg_shift_loader.sv
// Self-checking bench for gpio_cfg_shift_loader: directed table, corner
// sequences and a random phase against a queue-based reference model.
module tb_gpio_cfg_shift_loader;

  localparam int CFG_W = 10;
`ifdef GPIO_CFG_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int SR_W = CFG_W + PAR_W;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic [CFG_W-1:0] gpio_defaults = 10'h00A;
  logic             cfg_reload = 1'b0;
  logic             serial_shift = 1'b0;
  logic             serial_data_in = 1'b0;
  logic             serial_load = 1'b0;
  logic             serial_data_out;
  logic [CFG_W-1:0] cfg_out;
  logic             cfg_valid;
  logic             short_load;
`ifdef GPIO_CFG_PARITY_EN
  logic             parity_err;
`endif

  gpio_cfg_shift_loader #(
    .CFG_W (CFG_W)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .gpio_defaults   (gpio_defaults),
    .cfg_reload      (cfg_reload),
    .serial_shift    (serial_shift),
    .serial_data_in  (serial_data_in),
    .serial_load     (serial_load),
    .serial_data_out (serial_data_out),
    .cfg_out         (cfg_out),
    .cfg_valid       (cfg_valid),
`ifdef GPIO_CFG_PARITY_EN
    .parity_err      (parity_err),
`endif
    .short_load      (short_load)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: the chain is a history of every bit shifted in; the
  // register is its newest SR_W entries and the chain output is the bit
  // that fell off the end.
  bit         q[$];
  bit         m_init;
  logic [9:0] m_cfg;
  bit         m_valid, m_short, m_perr, m_dout;
  int         m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < SR_W + 1; i++) q.push_back(1'b0);
    m_init = 1; m_cfg = '0; m_valid = 0; m_short = 0; m_perr = 0; m_dout = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    int         sz;
    logic [15:0] w;
    bit         par, clr;
    if (m_init) begin
      m_cfg = gpio_defaults; m_valid = 1; m_init = 0;
      return;
    end
    sz = q.size(); w = '0; par = 0; clr = 0;
    for (int i = 0; i < SR_W; i++) begin
      w   = {w[14:0], q[sz - SR_W + i]};
      par = par ^ q[sz - SR_W + i];
    end
    if (cfg_reload) begin
      m_cfg = gpio_defaults; m_short = 0; m_perr = 0; clr = 1;
    end else if (serial_load) begin
      if (m_cnt == SR_W) begin
        clr = 1;
        if (PAR_W == 0 || !par) begin
          m_cfg = 10'(w >> PAR_W); m_short = 0; m_perr = 0;
        end else begin
          m_perr = 1;
        end
      end else begin
        m_short = 1;
      end
    end
    if (serial_shift) q.push_back(serial_data_in);
    if (clr) m_cnt = serial_shift ? 1 : 0;
    else if (serial_shift && m_cnt < SR_W) m_cnt++;
    m_dout = q[q.size() - 1 - SR_W];
    while (q.size() > 64) void'(q.pop_front());
  endtask

  task automatic cyc(input bit sh, input bit d, input bit ld, input bit rl);
    serial_shift = sh; serial_data_in = d; serial_load = ld; cfg_reload = rl;
    @(posedge clk);
    model_step();
    #1;
    chk("model_cfg_out", 32'(cfg_out), 32'(m_cfg));
    chk("model_cfg_valid", 32'(cfg_valid), 32'(m_valid));
    chk("model_short_load", 32'(short_load), 32'(m_short));
    chk("model_serial_data_out", 32'(serial_data_out), 32'(m_dout));
`ifdef GPIO_CFG_PARITY_EN
    chk("model_parity_err", 32'(parity_err), 32'(m_perr));
`endif
  endtask

  // Serial word for a data value, with the parity bit appended when enabled
  function automatic logic [15:0] mk(input logic [9:0] v);
`ifdef GPIO_CFG_PARITY_EN
    return {5'b0, v, ^v};
`else
    return {6'b0, v};
`endif
  endfunction

  task automatic shift_bits(input logic [15:0] bits, input int n);
    for (int k = n - 1; k >= 0; k--) cyc(1'b1, bits[k], 1'b0, 1'b0);
  endtask

  typedef struct {
    string      name;
    logic [15:0] bits;
    int         nbits;
    bit         ld;
    bit         rl;
    logic [9:0] exp_cfg;
    bit         exp_short;
  } vec_t;

  vec_t vt[7];

  initial begin
    logic [15:0] pat;

    vt[0] = '{"full_load_3c5",  mk(10'h3C5), SR_W,     1, 0, 10'h3C5, 0};
    vt[1] = '{"short_4bits",    16'h000B,    4,        1, 0, 10'h3C5, 1};
    vt[2] = '{"reload_clr",     16'h0000,    0,        0, 1, 10'h00A, 0};
    vt[3] = '{"full_load_155",  mk(10'h155), SR_W,     1, 0, 10'h155, 0};
    vt[4] = '{"reload_over_ld", mk(10'h2AA), SR_W,     1, 1, 10'h00A, 0};
    vt[5] = '{"saturate_load",  mk(10'h3FF) | (16'h3 << SR_W), SR_W + 2, 1, 0, 10'h3FF, 0};
    vt[6] = '{"one_short",      mk(10'h0F0), SR_W - 1, 1, 0, 10'h3FF, 1};

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cfg_out", 32'(cfg_out), 32'h0);
    chk("rst_cfg_valid", 32'(cfg_valid), 32'h0);
    chk("rst_short_load", 32'(short_load), 32'h0);
    chk("rst_serial_data_out", 32'(serial_data_out), 32'h0);
    resetn = 1'b1;
    cyc(0, 0, 0, 0);
    chk("init_cfg_out", 32'(cfg_out), 32'h00A);
    chk("init_cfg_valid", 32'(cfg_valid), 32'h1);

    // Load a word, then watch it replay out of the chain MSB first
    pat = mk(10'h3C5);
    shift_bits(pat, SR_W);
    cyc(0, 0, 1, 0);
    chk("load_3c5_cfg", 32'(cfg_out), 32'h3C5);
    chk("load_3c5_short", 32'(short_load), 32'h0);
    for (int k = SR_W - 1; k >= 0; k--) begin
      cyc(1, 0, 0, 0);
      chk("replay_dout", 32'(serial_data_out), 32'(pat[k]));
    end

    for (int i = 0; i < 7; i++) begin
      shift_bits(vt[i].bits, vt[i].nbits);
      cyc(0, 0, vt[i].ld, vt[i].rl);
      chk({vt[i].name, "_cfg"}, 32'(cfg_out), 32'(vt[i].exp_cfg));
      chk({vt[i].name, "_short"}, 32'(short_load), 32'(vt[i].exp_short));
    end

    // Shift and load together: load takes the old word, the shift starts the next
    shift_bits(mk(10'h155), SR_W);
    pat = mk(10'h2E7);
    cyc(1, pat[SR_W-1], 1, 0);
    chk("shld_cfg", 32'(cfg_out), 32'h155);
    for (int k = SR_W - 2; k >= 0; k--) cyc(1, pat[k], 0, 0);
    cyc(0, 0, 1, 0);
    chk("shld_next_cfg", 32'(cfg_out), 32'h2E7);
    chk("shld_next_short", 32'(short_load), 32'h0);
    shift_bits(mk(10'h0F0), SR_W);
    cyc(0, 0, 1, 1);
    chk("rl_ld_cfg", 32'(cfg_out), 32'h00A);

`ifdef GPIO_CFG_PARITY_EN
    shift_bits({5'b0, 10'h3C5, 1'b0}, SR_W);
    cyc(0, 0, 1, 0);
    chk("par_good_cfg", 32'(cfg_out), 32'h3C5);
    chk("par_good_err", 32'(parity_err), 32'h0);
    shift_bits({5'b0, 10'h3C4, 1'b0}, SR_W);
    cyc(0, 0, 1, 0);
    chk("par_bad_cfg", 32'(cfg_out), 32'h3C5);
    chk("par_bad_err", 32'(parity_err), 32'h1);
    shift_bits(mk(10'h1A2), SR_W);
    cyc(0, 0, 1, 0);
    chk("par_recover_cfg", 32'(cfg_out), 32'h1A2);
    chk("par_recover_err", 32'(parity_err), 32'h0);
`endif

    // Reset in the middle of shifting a word
    shift_bits(16'h001F, 5);
    #2;
    resetn = 1'b0;
    serial_shift = 1'b0;
    #1;
    chk("midrst_cfg_out", 32'(cfg_out), 32'h0);
    chk("midrst_cfg_valid", 32'(cfg_valid), 32'h0);
    chk("midrst_short", 32'(short_load), 32'h0);
    chk("midrst_dout", 32'(serial_data_out), 32'h0);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    cyc(1, 1, 1, 0);
    chk("midrst_init_cfg", 32'(cfg_out), 32'h00A);
    chk("midrst_init_valid", 32'(cfg_valid), 32'h1);

    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 99) < 75, 1'($urandom_range(0, 1)),
          $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
